// File: rtl/chirp_pkg.sv
// Shared encodings for the chirp phase-increment generator: sweep modes,
// controller states and the default frequency-to-phase scale constant.
package chirp_pkg;

  typedef enum logic [1:0] {
    MODE_CW   = 2'd0,
    MODE_UP   = 2'd1,
    MODE_DOWN = 2'd2,
    MODE_TRI  = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_CONV  = 3'd2,
    ST_XFER  = 3'd3,
    ST_DWELL = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // 1.3107 phase-increment LSBs per kHz, Q14
  localparam int K_FRAC_DEF  = 14;
  localparam int K_SCALE_DEF = 21475;

endpackage

// File: rtl/pinc_scale.sv
// Combinational frequency-word to phase-increment conversion:
// full-width multiply by the scale constant, round half up, saturate.
module pinc_scale
  import chirp_pkg::*;
#(
  parameter int FREQ_W  = 10,
  parameter int PINC_W  = 17,
  parameter int K_FRAC  = K_FRAC_DEF,
  parameter int K_SCALE = K_SCALE_DEF
) (
  input  logic [FREQ_W-1:0] freq,
  output logic [PINC_W-1:0] pinc
);

  localparam int PROD_W = FREQ_W + 16;
  localparam int SH_W   = PROD_W - K_FRAC;
  localparam int WIDE_W = (SH_W > PINC_W) ? SH_W : PINC_W;
  localparam logic [WIDE_W-1:0] PINC_MAX = WIDE_W'({PINC_W{1'b1}});

  logic [PROD_W-1:0] prod_s;
  logic [PROD_W-1:0] sum_s;
  logic [WIDE_W-1:0] scaled_s;

  // K_SCALE stays below 2^16, so adding the rounding half cannot overflow
  assign prod_s   = PROD_W'(freq) * PROD_W'(K_SCALE);
  assign sum_s    = prod_s + (PROD_W'(1'b1) << (K_FRAC - 1));
  assign scaled_s = WIDE_W'(sum_s >> K_FRAC);

  // Clamp to the largest representable increment
  always_comb begin
    if (scaled_s > PINC_MAX) begin
      pinc = PINC_MAX[PINC_W-1:0];
    end else begin
      pinc = scaled_s[PINC_W-1:0];
    end
  end

endmodule

// File: rtl/chirp_phase_gen.sv
// Frequency sweep controller (CW / up / down / triangle) that issues scaled
// phase increments to the DDS over a valid/ready handshake.
module chirp_phase_gen
  import chirp_pkg::*;
#(
  parameter int FREQ_W  = 10,
  parameter int PINC_W  = 17,
  parameter int K_FRAC  = K_FRAC_DEF,
  parameter int K_SCALE = K_SCALE_DEF,
  parameter int DWELL_W = 16
) (
  input  logic               aclk,
  input  logic               aresetn,
  input  logic               start,
  input  logic               stop,
  input  logic [1:0]         mode,
  input  logic               cont,
  input  logic [FREQ_W-1:0]  f_start,
  input  logic [FREQ_W-1:0]  f_stop,
  input  logic [FREQ_W-1:0]  f_step,
  input  logic [DWELL_W-1:0] dwell,
  output logic [PINC_W-1:0]  m_tdata,
  output logic               m_tvalid,
  input  logic               m_tready,
  output logic               busy,
  output logic               done
);

  state_e             state_r;
  mode_e              mode_r;
  logic               cont_r;
  logic [FREQ_W-1:0]  f_start_r;
  logic [FREQ_W-1:0]  f_stop_r;
  logic [FREQ_W-1:0]  f_step_r;
  logic [DWELL_W-1:0] dwell_r;
  logic [FREQ_W-1:0]  cur_f_r;
  logic               dir_up_r;
  logic [DWELL_W-1:0] cnt_r;
  logic               stop_pend_r;

  logic [PINC_W-1:0]  pinc_s;
  logic [FREQ_W-1:0]  next_f_s;
  logic [FREQ_W-1:0]  tri_dn_s;
  logic               next_dir_up_s;
  logic               sweep_end_s;
  logic               dwell_hit_s;

  function automatic logic [FREQ_W-1:0] step_up(input logic [FREQ_W-1:0] cur,
                                                input logic [FREQ_W-1:0] step,
                                                input logic [FREQ_W-1:0] hi);
    logic [FREQ_W:0] sum;
    sum = {1'b0, cur} + {1'b0, step};
    if (sum >= {1'b0, hi}) begin
      step_up = hi;
    end else begin
      step_up = sum[FREQ_W-1:0];
    end
  endfunction

  function automatic logic [FREQ_W-1:0] step_down(input logic [FREQ_W-1:0] cur,
                                                  input logic [FREQ_W-1:0] step,
                                                  input logic [FREQ_W-1:0] lo);
    if ((cur <= lo) || ((cur - lo) <= step)) begin
      step_down = lo;
    end else begin
      step_down = cur - step;
    end
  endfunction

  pinc_scale #(
    .FREQ_W (FREQ_W),
    .PINC_W (PINC_W),
    .K_FRAC (K_FRAC),
    .K_SCALE(K_SCALE)
  ) u_scale (
    .freq(cur_f_r),
    .pinc(pinc_s)
  );

  // The count starts at 1 on entry, so dwell=0 also ends after one cycle
  assign dwell_hit_s = (cnt_r >= dwell_r);

  // Next sweep frequency and end-of-sweep detection, evaluated at dwell expiry
  always_comb begin
    next_f_s      = cur_f_r;
    next_dir_up_s = dir_up_r;
    sweep_end_s   = 1'b0;
    tri_dn_s      = step_down(cur_f_r, f_step_r, f_start_r);
    case (mode_r)
      MODE_CW: begin
        next_f_s = cur_f_r;
      end
      MODE_UP: begin
        if (cur_f_r >= f_stop_r) begin
          sweep_end_s = 1'b1;
        end else begin
          next_f_s = step_up(cur_f_r, f_step_r, f_stop_r);
        end
      end
      MODE_DOWN: begin
        if (cur_f_r <= f_stop_r) begin
          sweep_end_s = 1'b1;
        end else begin
          next_f_s = step_down(cur_f_r, f_step_r, f_stop_r);
        end
      end
      MODE_TRI: begin
        if (f_start_r >= f_stop_r) begin
          next_f_s = cur_f_r;
        end else if (dir_up_r && (cur_f_r < f_stop_r)) begin
          next_f_s = step_up(cur_f_r, f_step_r, f_stop_r);
        end else if (tri_dn_s == f_start_r) begin
          sweep_end_s = 1'b1;
        end else begin
          next_f_s      = tri_dn_s;
          next_dir_up_s = 1'b0;
        end
      end
      default: begin
        next_f_s = cur_f_r;
      end
    endcase
  end

  // Sweep controller with registered handshake and status outputs
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_r     <= ST_IDLE;
      mode_r      <= MODE_CW;
      cont_r      <= 1'b0;
      f_start_r   <= '0;
      f_stop_r    <= '0;
      f_step_r    <= '0;
      dwell_r     <= '0;
      cur_f_r     <= '0;
      dir_up_r    <= 1'b1;
      cnt_r       <= '0;
      stop_pend_r <= 1'b0;
      m_tdata     <= '0;
      m_tvalid    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          m_tvalid    <= 1'b0;
          stop_pend_r <= 1'b0;
          if (start) begin
            mode_r    <= mode_e'(mode);
            cont_r    <= cont;
            f_start_r <= f_start;
            f_stop_r  <= f_stop;
            f_step_r  <= f_step;
            dwell_r   <= dwell;
            busy      <= 1'b1;
            state_r   <= ST_LOAD;
          end else begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_LOAD: begin
          if (stop) begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            cur_f_r  <= f_start_r;
            dir_up_r <= (mode_r != MODE_DOWN);
            state_r  <= ST_CONV;
          end
        end
        ST_CONV: begin
          if (stop) begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            m_tdata  <= pinc_s;
            m_tvalid <= 1'b1;
            state_r  <= ST_XFER;
          end
        end
        ST_XFER: begin
          // A stop here is remembered so the offered value is not torn
          if (m_tready) begin
            m_tvalid <= 1'b0;
            if (stop || stop_pend_r) begin
              busy        <= 1'b0;
              stop_pend_r <= 1'b0;
              state_r     <= ST_IDLE;
            end else begin
              cnt_r   <= DWELL_W'(1'b1);
              state_r <= ST_DWELL;
            end
          end else begin
            stop_pend_r <= stop_pend_r | stop;
          end
        end
        ST_DWELL: begin
          if (stop) begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end else if (!dwell_hit_s) begin
            cnt_r <= cnt_r + DWELL_W'(1'b1);
          end else if (!sweep_end_s) begin
            cur_f_r  <= next_f_s;
            dir_up_r <= next_dir_up_s;
            state_r  <= ST_CONV;
          end else if (cont_r) begin
            cur_f_r  <= f_start_r;
            dir_up_r <= (mode_r != MODE_DOWN);
            state_r  <= ST_CONV;
          end else begin
            done    <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy     <= 1'b0;
          m_tvalid <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chirp_phase_gen.sv
// Directed bench for chirp_phase_gen: a vector table of sweeps with
// hand-computed increments, plus backpressure, stop and reset sequences.
module tb_chirp_phase_gen;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        start, stop, cont, m_tready;
  logic [1:0]  mode;
  logic [9:0]  f_start, f_stop, f_step;
  logic [15:0] dwell;
  logic [16:0] m_tdata;
  logic        m_tvalid, busy, done;
  logic [9:0]  s_tdata;
  logic        s_tvalid, s_busy, s_done;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [1:0]        mode;
    logic              cont;
    logic [9:0]        fs;
    logic [9:0]        fe;
    logic [9:0]        fst;
    logic [15:0]       dw;
    logic [3:0]        n;
    logic [0:6][16:0]  exp;
    logic              exp_done;
  } vec_t;

  vec_t tbl [12];

  always #5 aclk = ~aclk;

  chirp_phase_gen dut (
    .aclk(aclk), .aresetn(aresetn), .start(start), .stop(stop), .mode(mode),
    .cont(cont), .f_start(f_start), .f_stop(f_stop), .f_step(f_step),
    .dwell(dwell), .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .busy(busy), .done(done)
  );

  chirp_phase_gen #(.PINC_W(10)) dut_sat (
    .aclk(aclk), .aresetn(aresetn), .start(start), .stop(stop), .mode(mode),
    .cont(cont), .f_start(f_start), .f_stop(f_stop), .f_step(f_step),
    .dwell(dwell), .m_tdata(s_tdata), .m_tvalid(s_tvalid), .m_tready(m_tready),
    .busy(s_busy), .done(s_done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t mkv(input logic [1:0] m, input logic c, input logic [9:0] a,
                               input logic [9:0] b, input logic [9:0] s, input logic [15:0] d,
                               input logic [3:0] n, input logic [0:6][16:0] e, input logic ed);
    vec_t v;
    v.mode = m; v.cont = c; v.fs = a; v.fe = b; v.fst = s; v.dw = d;
    v.n = n; v.exp = e; v.exp_done = ed;
    return v;
  endfunction

  function automatic logic [16:0] sat10(input logic [16:0] x);
    return (x > 17'd1023) ? 17'd1023 : x;
  endfunction

  task automatic wait_valid(output int cycles);
    cycles = 0;
    do begin
      @(negedge aclk);
      start = 1'b0;
      cycles++;
    end while (!m_tvalid && cycles < 100);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int cyc, got, last, dweff, j;
    bit seen_done;
    cyc = 0; got = 0; last = 0; seen_done = 1'b0;
    dweff = (v.dw == 16'd0) ? 1 : int'(v.dw);
    @(negedge aclk);
    mode = v.mode; cont = v.cont; f_start = v.fs; f_stop = v.fe;
    f_step = v.fst; dwell = v.dw; m_tready = 1'b1; start = 1'b1;
    while (got < int'(v.n) && cyc < 400) begin
      @(negedge aclk);
      start = 1'b0;
      cyc++;
      if (done) seen_done = 1'b1;
      if (m_tvalid) begin
        check($sformatf("v%0d value%0d", idx, got), m_tdata, v.exp[got]);
        check($sformatf("v%0d sat value%0d", idx, got), s_tdata, sat10(v.exp[got]));
        if (got == 0) check($sformatf("v%0d first latency", idx), cyc, 3);
        else check($sformatf("v%0d update gap%0d", idx, got), cyc - last, dweff + 2);
        last = cyc;
        got++;
      end
    end
    check($sformatf("v%0d values seen", idx), got, v.n);
    check($sformatf("v%0d early done", idx), seen_done, 1'b0);
    if (v.exp_done) begin
      j = 0;
      do begin
        @(negedge aclk);
        j++;
      end while (!done && j < dweff + 6);
      check($sformatf("v%0d done latency", idx), j, dweff + 1);
      check($sformatf("v%0d busy with done", idx), busy, 1'b1);
      @(negedge aclk);
      check($sformatf("v%0d busy after done", idx), busy, 1'b0);
      check($sformatf("v%0d done width", idx), done, 1'b0);
    end else begin
      @(negedge aclk);
      check($sformatf("v%0d no done", idx), done, 1'b0);
      stop = 1'b1;
      @(negedge aclk);
      stop = 1'b0;
      check($sformatf("v%0d busy after stop", idx), busy, 1'b0);
      check($sformatf("v%0d valid after stop", idx), m_tvalid, 1'b0);
    end
    @(negedge aclk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    aresetn = 1'b0; start = 1'b0; stop = 1'b0; cont = 1'b0; m_tready = 1'b1;
    mode = 2'd0; f_start = 10'd0; f_stop = 10'd0; f_step = 10'd0; dwell = 16'd0;

    tbl[0]  = mkv(2'd0, 1'b0, 10'd1000, 10'd0,   10'd0,  16'd1, 4'd3,
                  {17'd1311, 17'd1311, 17'd1311, 17'd0, 17'd0, 17'd0, 17'd0}, 1'b0);
    tbl[1]  = mkv(2'd0, 1'b0, 10'd100,  10'd0,   10'd0,  16'd0, 4'd2,
                  {17'd131, 17'd131, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0}, 1'b0);
    tbl[2]  = mkv(2'd0, 1'b0, 10'd1023, 10'd0,   10'd0,  16'd1, 4'd2,
                  {17'd1341, 17'd1341, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0}, 1'b0);
    tbl[3]  = mkv(2'd1, 1'b0, 10'd100,  10'd130, 10'd10, 16'd4, 4'd4,
                  {17'd131, 17'd144, 17'd157, 17'd170, 17'd0, 17'd0, 17'd0}, 1'b1);
    tbl[4]  = mkv(2'd1, 1'b0, 10'd100,  10'd130, 10'd20, 16'd4, 4'd3,
                  {17'd131, 17'd157, 17'd170, 17'd0, 17'd0, 17'd0, 17'd0}, 1'b1);
    tbl[5]  = mkv(2'd3, 1'b1, 10'd100,  10'd120, 10'd10, 16'd1, 4'd7,
                  {17'd131, 17'd144, 17'd157, 17'd144, 17'd131, 17'd144, 17'd157}, 1'b0);
    tbl[6]  = mkv(2'd2, 1'b0, 10'd130,  10'd100, 10'd10, 16'd2, 4'd4,
                  {17'd170, 17'd157, 17'd144, 17'd131, 17'd0, 17'd0, 17'd0}, 1'b1);
    tbl[7]  = mkv(2'd1, 1'b0, 10'd120,  10'd100, 10'd10, 16'd1, 4'd1,
                  {17'd157, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0}, 1'b1);
    tbl[8]  = mkv(2'd3, 1'b0, 10'd120,  10'd100, 10'd10, 16'd1, 4'd3,
                  {17'd157, 17'd157, 17'd157, 17'd0, 17'd0, 17'd0, 17'd0}, 1'b0);
    tbl[9]  = mkv(2'd1, 1'b0, 10'd100,  10'd130, 10'd0,  16'd1, 4'd4,
                  {17'd131, 17'd131, 17'd131, 17'd131, 17'd0, 17'd0, 17'd0}, 1'b0);
    tbl[10] = mkv(2'd2, 1'b1, 10'd120,  10'd100, 10'd20, 16'd1, 4'd4,
                  {17'd157, 17'd131, 17'd157, 17'd131, 17'd0, 17'd0, 17'd0}, 1'b0);
    tbl[11] = mkv(2'd0, 1'b0, 10'd700,  10'd0,   10'd0,  16'd1, 4'd2,
                  {17'd918, 17'd918, 17'd0, 17'd0, 17'd0, 17'd0, 17'd0}, 1'b0);

    repeat (3) @(negedge aclk);
    check("reset m_tvalid", m_tvalid, 1'b0);
    check("reset m_tdata", m_tdata, 17'd0);
    check("reset busy", busy, 1'b0);
    check("reset done", done, 1'b0);
    check("reset sat m_tdata", s_tdata, 10'd0);
    aresetn = 1'b1;
    @(negedge aclk);

    for (int i = 0; i < 12; i++) run_vec(tbl[i], i);

    // Backpressure on the second value, then stop while a transfer is pending
    @(negedge aclk);
    mode = 2'd1; cont = 1'b0; f_start = 10'd100; f_stop = 10'd130; f_step = 10'd10;
    dwell = 16'd2; m_tready = 1'b1; start = 1'b1;
    wait_valid(k);
    check("bp first valid", m_tvalid, 1'b1);
    check("bp first value", m_tdata, 17'd131);
    @(negedge aclk);
    m_tready = 1'b0;
    wait_valid(k);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp hold valid%0d", i), m_tvalid, 1'b1);
      check($sformatf("bp hold data%0d", i), m_tdata, 17'd144);
      if (i < 9) @(negedge aclk);
    end
    m_tready = 1'b1;
    wait_valid(k);
    check("bp gap after accept", k, 4);
    check("bp third value", m_tdata, 17'd157);
    m_tready = 1'b0;
    stop = 1'b1;
    @(negedge aclk);
    stop = 1'b0;
    check("xfer stop valid held", m_tvalid, 1'b1);
    check("xfer stop data held", m_tdata, 17'd157);
    check("xfer stop busy held", busy, 1'b1);
    m_tready = 1'b1;
    @(negedge aclk);
    check("xfer stop busy", busy, 1'b0);
    check("xfer stop valid", m_tvalid, 1'b0);

    // Reset while a value is being offered
    @(negedge aclk);
    mode = 2'd0; f_start = 10'd1000; dwell = 16'd1; m_tready = 1'b0; start = 1'b1;
    wait_valid(k);
    check("rst pre valid", m_tvalid, 1'b1);
    check("rst pre data", m_tdata, 17'd1311);
    check("rst pre sat data", s_tdata, 10'd1023);
    aresetn = 1'b0;
    @(negedge aclk);
    check("rst m_tvalid", m_tvalid, 1'b0);
    check("rst m_tdata", m_tdata, 17'd0);
    check("rst busy", busy, 1'b0);
    check("rst sat m_tvalid", s_tvalid, 1'b0);
    check("rst sat m_tdata", s_tdata, 10'd0);
    aresetn = 1'b1;
    m_tready = 1'b1;
    @(negedge aclk);
    run_vec(tbl[0], 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/chirp_phase_gen.md
# chirp_phase_gen

Parametrised frequency-to-phase-increment generator for the radar waveform path, feeding the DDS phase-increment channel over an AXI-stream style handshake. It converts a frequency word to a phase increment with fixed-point scaling, rounding and saturation. It also runs CW, up-ramp, down-ramp and triangle frequency sweeps with a programmable step size and dwell time.

## Interface
- FREQ_W, 10, frequency word width (kHz units)
- PINC_W, 17, phase-increment output width
- K_FRAC, 14, fractional bits of the scale constant
- K_SCALE, 21475, phase increment per kHz in Q(K_FRAC), i.e. 1.3107·2^14
- DWELL_W, 16, dwell counter width
- aclk  in  1  clock
- aresetn  in  1  reset, synchronous, active-low; clock aclk
- start  in  1  one-cycle pulse; latches the config and begins operation
- stop  in  1  one-cycle pulse; aborts operation
- mode  in  2  0 CW, 1 up-ramp, 2 down-ramp, 3 triangle
- cont  in  1  1: repeat the sweep; 0: single sweep then done
- f_start  in  FREQ_W  first frequency
- f_stop  in  FREQ_W  end frequency (ignored in CW)
- f_step  in  FREQ_W  step per dwell
- dwell  in  DWELL_W  cycles each value is held after acceptance; 0 treated as 1
- m_tdata  out  PINC_W  phase increment
- m_tvalid  out  1  new increment available
- m_tready  in  1  DDS accepts increment
- busy  out  1  high in every state other than IDLE
- done  out  1  one-cycle pulse at the end of a single sweep

## Operation
- States are IDLE, LOAD, CONV, XFER, DWELL and DONE.
- **IDLE:** on start, latch mode, cont, f_start, f_stop, f_step and dwell; go to LOAD. Config inputs are don't-care outside the start cycle.
- **LOAD:** set cur_f = f_start and dir = up (down for mode 2); go to CONV.
- **CONV:** pinc = (cur_f·K_SCALE + 2^(K_FRAC−1)) >> K_FRAC.
  - The product is full width, FREQ_W+16 bits.
  - The result saturates to 2^PINC_W−1.
  - The result is registered into m_tdata, and m_tvalid is set. Go to XFER.
- **XFER:** hold m_tvalid and m_tdata stable until m_tready; on the handshake, clear m_tvalid and go to DWELL.
- **DWELL:** count dwell cycles (minimum 1), then compute the next frequency:
  - CW: cur_f is unchanged and the same value is re-issued.
  - Up: next = min(cur_f+f_step, f_stop). If cur_f was already f_stop, the sweep ends.
  - Down: next = max(cur_f−f_step, f_stop), computed without wrap. If cur_f was already f_stop, the sweep ends.
  - Triangle: ramp up to f_stop, flip dir, ramp down to f_start, flip dir. Reaching f_start after the down leg ends the sweep.
  - If the sweep has not ended, go to CONV.
- **End of sweep:** with cont=1, reload f_start (and the initial dir) and go to CONV. With cont=0, go to DONE.
- **DONE:** done=1 for one cycle, then IDLE.
- **Boundary cases:**
  - f_step=0 in a ramp mode: the value repeats indefinitely; done never fires.
  - Up-ramp with f_start≥f_stop: one value f_start, then the sweep ends. Down-ramp with f_start≤f_stop behaves the same way.
  - Triangle with f_start≥f_stop: behaves as CW on f_start.
- **stop:**
  - In XFER, the pending transfer completes, then IDLE.
  - In any other state, go to IDLE next cycle with m_tvalid=0.
  - start is ignored while busy.
- **Reset:** synchronous and valid in any state. It gives state IDLE, m_tdata=0, m_tvalid=0, busy=0, done=0, cur_f=0. No handshake survives reset.

## Timing
- start sampled high at cycle N: LOAD at N+1, CONV at N+2, m_tvalid=1 with data at N+3.
- Handshake at cycle M: the next value is valid at M+dwell+2 (DWELL takes dwell cycles, then CONV takes one).
- In CW with dwell=1 and m_tready tied high, the update period is 3 cycles.
- done asserts the cycle after the final DWELL completes. busy falls one cycle later.
- stop at cycle N outside XFER: busy=0 and m_tvalid=0 at N+1.

## Structure
- Shared package chirp_pkg holds:
  - the mode encoding (CW/UP/DOWN/TRI);
  - the state enum;
  - default K_SCALE and K_FRAC.
- One sub-module, pinc_scale: a combinational multiply, round and saturate (FREQ_W → PINC_W). It is reusable by any fixed-frequency path and is checked standalone against a real-arithmetic model.

## Test plan
- **CW, rounding:** mode 0, f_start=1000, m_tready=1 → m_tdata=1311, first m_tvalid 3 cycles after start. f_start=100 → 131. f_start=1023 → 1341.
- **Up-ramp:** 100→130, f_step=10, dwell=4, cont=0 → 1311-scaled sequence 131, 144, 157, 170, then done pulse and busy low. Repeat with f_step=20 → 131, 157, 170 (clamped).
- **Backpressure:** hold m_tready low for 10 cycles on the second value → m_tdata stable and m_tvalid held; dwell starts only after acceptance.
- **Triangle with cont=1:** 100↔120, step 10 → 131, 144, 157, 144, 131, 144, …; done never fires. Pulse stop outside XFER → IDLE next cycle.
- **Saturation, override PINC_W=10:** f_start=1000 → m_tdata=1023.
- **Reset mid-XFER:** aresetn low in XFER → next cycle m_tvalid=0, m_tdata=0, busy=0. A start after reset restarts cleanly.
